// File: rtl/nr_bit_pkg.sv
// Shared nanoRisk byte/nibble definitions: widths, narrower FSM states and
// nibble helpers used by the extender, compactor and narrower.
package nr_bit_pkg;

    localparam int BYTE_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } nr_state_e;

    function automatic logic [NIB_W-1:0] pick_nibble(
        input logic [BYTE_W-1:0] b,
        input logic              take_high
    );
        return take_high ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
    endfunction

    // A byte collapses to one nibble only when it is a pure zero extension.
    function automatic logic is_ext(
        input logic [BYTE_W-1:0] b,
        input logic              compress
    );
        return compress && (b[BYTE_W-1:NIB_W] == {NIB_W{1'b0}});
    endfunction

endpackage

// File: rtl/nr_bit_narrow.sv
// Byte-to-nibble narrower: accepts bytes on one valid/ready stream and emits
// one or two nibbles per byte on a second stream, collapsing zero-extended bytes.
module nr_bit_narrow
    import nr_bit_pkg::*;
#(
    parameter bit MSN_FIRST = 1'b0,
    parameter bit COMPRESS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NIB_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_ext,
    output logic              out_zero,
    output logic [BYTE_W-1:0] byte_cnt
);

    nr_state_e         state_q, state_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              out_valid_q, out_valid_d;
    logic [NIB_W-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_ext_q, out_ext_d;
    logic              out_zero_q, out_zero_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;

    logic byte_done_s;
    logic in_ready_s;
    logic in_acc_s;
    logic ext_s;

    // Next-state, output-register and handshake logic.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ext_d   = out_ext_q;
        out_zero_d  = out_zero_q;
        byte_cnt_d  = byte_cnt_q;

        byte_done_s = out_valid_q && out_ready && out_last_q;
        in_ready_s  = !rst && ((state_q == IDLE) || byte_done_s);
        in_acc_s    = in_valid && in_ready_s;
        ext_s       = is_ext(in_data, COMPRESS);

        case (state_q)
            EMIT0: begin
                if (out_ready && !out_last_q) begin
                    state_d    = EMIT1;
                    out_data_d = pick_nibble(hold_q, !MSN_FIRST);
                    out_last_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            IDLE, EMIT1: begin
                state_d = state_q;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        if (byte_done_s) begin
            byte_cnt_d  = byte_cnt_q + 8'd1;
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            byte_cnt_d = byte_cnt_q;
        end

        // A new byte may load on the same edge that retires the previous one.
        if (in_acc_s) begin
            hold_d      = in_data;
            state_d     = EMIT0;
            out_valid_d = 1'b1;
            out_ext_d   = ext_s;
            out_zero_d  = ~|in_data;
            out_last_d  = ext_s;
            out_data_d  = pick_nibble(in_data, MSN_FIRST && !ext_s);
        end else begin
            hold_d = hold_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 4'h0;
            out_last_q  <= 1'b0;
            out_ext_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            byte_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ext_q   <= out_ext_d;
            out_zero_q  <= out_zero_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ext   = out_ext_q;
    assign out_zero  = out_zero_q;
    assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_nr_bit_narrow.sv
// Scoreboard bench for nr_bit_narrow: four parameter variants, each with its
// own driver, reference model queue and output monitor.
module tb_nr_bit_narrow;

    typedef struct packed {
        logic [3:0] d;
        logic       last;
        logic       ext;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, inst, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam bit MSN = (g == 1) || (g == 2);
        localparam bit CMP = (g == 0) || (g == 2);

        logic       rst = 1'b1;
        logic [7:0] in_data = 8'h00;
        logic       in_valid = 1'b0;
        logic       in_ready;
        logic [3:0] out_data;
        logic       out_valid;
        logic       out_ready = 1'b0;
        logic       out_last;
        logic       out_ext;
        logic       out_zero;
        logic [7:0] byte_cnt;

        exp_t q[$];
        int   cnt_m = 0;
        int   rdy_mode = 1;
        bit   done_b = 1'b0;

        nr_bit_narrow #(.MSN_FIRST(MSN), .COMPRESS(CMP)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .out_data (out_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_last (out_last),
            .out_ext  (out_ext),
            .out_zero (out_zero),
            .byte_cnt (byte_cnt)
        );

        function automatic int nibs(input logic [7:0] b);
            return (CMP && (b < 8'd16)) ? 1 : 2;
        endfunction

        // Reference model: expected nibble sequence for one byte.
        function automatic void push_byte(input logic [7:0] b);
            int lo;
            int hi;
            logic z;
            lo = int'(b) % 16;
            hi = int'(b) / 16;
            z  = (b == 8'h00);
            if (CMP && hi == 0) begin
                q.push_back(exp_t'{d: 4'(lo), last: 1'b1, ext: 1'b1, zero: z});
            end else if (MSN) begin
                q.push_back(exp_t'{d: 4'(hi), last: 1'b0, ext: 1'b0, zero: z});
                q.push_back(exp_t'{d: 4'(lo), last: 1'b1, ext: 1'b0, zero: z});
            end else begin
                q.push_back(exp_t'{d: 4'(lo), last: 1'b0, ext: 1'b0, zero: z});
                q.push_back(exp_t'{d: 4'(hi), last: 1'b1, ext: 1'b0, zero: z});
            end
        endfunction

        task automatic set_rdy(input int m);
            rdy_mode = m;
            if (m == 1) out_ready = 1'b1;
            else if (m == 2) out_ready = 1'b0;
        endtask

        task automatic send(input logic [7:0] b, output int waits);
            bit acc;
            acc = 1'b0;
            waits = 0;
            in_valid = 1'b1;
            in_data = b;
            while (!acc && waits < 300) begin
                @(negedge clk);
                waits++;
                if (in_ready) begin
                    acc = 1'b1;
                    push_byte(b);
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            in_data = 8'($urandom);
            if (!acc) chk("accept_timeout", g, 32'd0, 32'd1);
            else chk("first_nibble_latency", g, 32'(out_valid), 32'd1);
        endtask

        task automatic send1(input logic [7:0] b);
            int w;
            send(b, w);
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (q.size() != 0 && n < 1000) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("drain_timeout", g, 32'(q.size()), 32'd0);
        endtask

        task automatic do_reset();
            rst = 1'b1;
            @(posedge clk);
            #1;
            q.delete();
            cnt_m = 0;
            chk("rst_out_valid", g, 32'(out_valid), 32'd0);
            chk("rst_byte_cnt", g, 32'(byte_cnt), 32'd0);
            chk("rst_in_ready", g, 32'(in_ready), 32'd0);
            chk("rst_outputs", g, 32'({out_data, out_last, out_ext, out_zero}), 32'd0);
            rst = 1'b0;
            #1;
            chk("rst_release_ready", g, 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        endtask

        // Consumer back-pressure generator.
        initial begin
            forever begin
                @(posedge clk);
                #1;
                case (rdy_mode)
                    0: out_ready = ($urandom_range(3) != 0);
                    1: out_ready = 1'b1;
                    default: out_ready = 1'b0;
                endcase
            end
        end

        // Monitor: pops the scoreboard on every nibble handshake.
        initial begin
            logic stall_p;
            exp_t prev;
            exp_t e;
            stall_p = 1'b0;
            prev = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    stall_p = 1'b0;
                end else begin
                    chk("in_ready", g, 32'(in_ready),
                        32'(!out_valid || (out_ready && out_last)));
                    if (stall_p)
                        chk("stall_hold", g,
                            32'({out_valid, out_data, out_last, out_ext, out_zero}),
                            32'({1'b1, prev}));
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            chk("unexpected_nibble", g, 32'(out_data), 32'hFFFF);
                        end else begin
                            e = q.pop_front();
                            chk("nibble", g, 32'({out_data, out_last, out_ext, out_zero}),
                                32'(e));
                        end
                        chk("byte_cnt", g, 32'(byte_cnt), 32'(cnt_m % 256));
                        if (out_last) cnt_m++;
                    end
                    stall_p = out_valid && !out_ready;
                    prev = {out_data, out_last, out_ext, out_zero};
                end
            end
        end

        // Directed cases followed by randomized traffic and counter wrap.
        initial begin
            int w;
            logic [7:0] b;
            do_reset();

            set_rdy(1);
            send1(8'hA5);
            send1(8'h07);
            send1(8'h00);
            drain();
            chk("cnt_after_basic", g, 32'(byte_cnt), 32'd3);

            set_rdy(2);
            send1(8'h3C);
            repeat (3) begin
                @(negedge clk);
                chk("stall_valid", g, 32'(out_valid), 32'd1);
                chk("stall_in_ready", g, 32'(in_ready), 32'd0);
                chk("stall_first_nib", g, 32'(out_data), MSN ? 32'h3 : 32'hC);
                @(posedge clk);
                #1;
            end
            set_rdy(1);
            drain();

            send(8'h12, w);
            chk("burst_gap0", g, 32'(w), 32'd1);
            send(8'h34, w);
            chk("burst_gap1", g, 32'(w), 32'(nibs(8'h12)));
            send(8'h05, w);
            chk("burst_gap2", g, 32'(w), 32'(nibs(8'h34)));
            drain();
            chk("cnt_after_burst", g, 32'(byte_cnt), 32'd7);

            send1(8'hBE);
            @(posedge clk);
            #1;
            do_reset();
            send1(8'h11);
            drain();
            chk("cnt_after_midreset", g, 32'(byte_cnt), 32'd1);

            set_rdy(0);
            for (int i = 0; i < 200; i++) begin
                b = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
                send1(b);
                repeat ($urandom_range(2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drain();

            do_reset();
            for (int i = 0; i < 255; i++) send1(8'($urandom_range(255)));
            drain();
            chk("cnt_255", g, 32'(byte_cnt), 32'd255);
            send1(8'hFF);
            drain();
            chk("cnt_wrap", g, 32'(byte_cnt), 32'd0);

            done_b = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(inst[0].done_b && inst[1].done_b && inst[2].done_b && inst[3].done_b)
               && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60000) begin
            tests++;
            fails++;
            $display("FAIL global_timeout: got %0d cycles, expected completion", n);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
